uart_hamming_transmitter: RTL and testbench

- UART transmitter: the sending end of the receiver's link.
- Takes a 4-bit nibble through a valid/ready handshake and encodes it to Hamming(7,4).
- Serialises the codeword as: start bit (low), 7 data bits LSB first, stop bit (high). Each bit is held CLKS_PER_BIT enabled cycles, matching the receiver's oversampling.
- Sits at the tile output, driving the tx line toward the receive-side tile.

---
 rtl/uart_hamming_transmitter_if.sv | 30 +++
 rtl/uart_hamming_transmitter.sv | 159 +++++++++++++++
 tb/tb_uart_hamming_transmitter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hamming_transmitter_if.sv
// Upstream nibble handshake plus serial line and status toward the receive-side tile.
interface uart_hamming_transmitter_if;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [1:0] state_out;
    logic       done_pulse;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  tx,
        input  busy,
        input  state_out,
        input  done_pulse
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output tx,
        output busy,
        output state_out,
        output done_pulse
    );
endinterface

// File: rtl/uart_hamming_transmitter.sv
// Hamming(7,4) UART transmitter: one nibble per 9*CLKS_PER_BIT-cycle frame, data_ready low while framing.
// Defining UART_TX_HOLD_BUF_EN adds a one-entry codeword buffer so frames can run back-to-back.
module uart_hamming_transmitter #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    uart_hamming_transmitter_if.slave bus
);
    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;
    logic             tx_r;
    logic             busy_r;
    logic             ready_r;
    logic             done_r;
    logic             xfer;
    logic             cyc_last;
    logic [6:0]       code;

    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    assign xfer     = ena && bus.data_valid && ready_r;
    assign cyc_last = (cyc_cnt == CNT_LAST);
    assign code     = hamming_encode(bus.data_in);

`ifdef UART_TX_HOLD_BUF_EN
    logic [6:0] hold_buf;
    logic       buf_full;
    logic       stop_end;
    assign stop_end = (state == STOP) && cyc_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            hold_buf <= '0;
            buf_full <= 1'b0;
`endif
        end else if (ena) begin
            done_r <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            ready_r <= !buf_full;
            // Mid-frame acceptance parks the codeword; at end of STOP it goes straight to the shifter instead.
            if (xfer && (state != IDLE) && !stop_end) begin
                hold_buf <= code;
                buf_full <= 1'b1;
                ready_r  <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    tx_r    <= 1'b1;
                    ready_r <= 1'b1;
                    if (xfer) begin
                        shreg   <= code;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= START;
                        busy_r  <= 1'b1;
                        tx_r    <= 1'b0;
`ifndef UART_TX_HOLD_BUF_EN
                        ready_r <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (cyc_last) begin
                        cyc_cnt <= '0;
                        state   <= DATA;
                        tx_r    <= shreg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cyc_last) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 3'd6) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_r    <= shreg[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cyc_last) begin
                        cyc_cnt <= '0;
                        done_r  <= 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                        if (buf_full) begin
                            shreg    <= hold_buf;
                            buf_full <= 1'b0;
                            ready_r  <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= START;
                            tx_r     <= 1'b0;
                        end else if (xfer) begin
                            shreg   <= code;
                            bit_cnt <= '0;
                            state   <= START;
                            tx_r    <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            tx_r   <= 1'b1;
                        end
`else
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        tx_r    <= 1'b1;
                        ready_r <= 1'b1;
`endif
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx         = tx_r;
    assign bus.busy       = busy_r;
    assign bus.state_out  = state;
    assign bus.data_ready = ready_r;
    assign bus.done_pulse = done_r;
endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// Randomized and directed stimulus for uart_hamming_transmitter, scored against a frame-position model.
module tb_uart_hamming_transmitter;
    localparam int CPB = 8;
    localparam int FRAME = 9 * CPB;
`ifdef UART_TX_HOLD_BUF_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;

    uart_hamming_transmitter_if bus();

    uart_hamming_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;

    // Reference model: a frame is just a position counter over 9 bit slots.
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [3:0] m_nib = '0;
    logic [3:0] m_pend = '0;
    bit         m_pend_full = 1'b0;
    bit         m_ready = 1'b0;
    bit         m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] ham(input logic [3:0] d);
        logic [6:0] c;
        logic       x;
        int         j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= 7; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        for (int p = 1; p <= 4; p = p * 2) begin
            x = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos & p) != 0) && (pos != p)) x = x ^ c[pos-1];
            c[p-1] = x;
        end
        return c;
    endfunction

    function automatic logic exp_tx();
        int k;
        logic [6:0] c;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 8) return 1'b1;
        c = ham(m_nib);
        return c[k-1];
    endfunction

    function automatic logic [1:0] exp_state();
        int k;
        if (!m_active) return 2'd0;
        k = m_pos / CPB;
        if (k == 0) return 2'd1;
        if (k <= 7) return 2'd2;
        return 2'd3;
    endfunction

    task automatic tick();
        bit xfer;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_pos = 0; m_pend_full = 1'b0;
            m_ready = 1'b0; m_done = 1'b0;
        end else if (ena) begin
            xfer = bus.data_valid && m_ready;
            m_done = 1'b0;
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_done = 1'b1;
                    if (m_pend_full) begin
                        m_nib = m_pend; m_pend_full = 1'b0; m_pos = 0;
                    end else if (xfer) begin
                        m_nib = bus.data_in; m_pos = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else if (xfer) begin
                    m_pend = bus.data_in; m_pend_full = 1'b1;
                end
            end else if (xfer) begin
                m_active = 1'b1; m_pos = 0; m_nib = bus.data_in;
            end
            m_ready = HOLD ? !m_pend_full : !m_active;
        end
        cyc++;
        #1;
        if (bus.done_pulse === 1'b1) n_done++;
        chk("tx", bus.tx, exp_tx());
        chk("busy", bus.busy, m_active);
        chk("state_out", bus.state_out, exp_state());
        chk("data_ready", bus.data_ready, m_ready);
        chk("done_pulse", bus.done_pulse, m_done);
    endtask

    task automatic send(input logic [3:0] nib);
        bit took;
        bus.data_in = nib;
        bus.data_valid = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 1000 && !took; i++) begin
            took = ena && !rst && m_ready;
            tick();
        end
        if (!took) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 2000 && n_done < target; i++) tick();
        if (n_done < target) chk("done_timeout", n_done, target);
    endtask

    task automatic run_until_pos(input int pos);
        for (int i = 0; i < 500 && m_pos < pos; i++) tick();
        if (m_pos != pos) chk("pos_timeout", m_pos, pos);
    endtask

    initial begin
        int t0;
        int base;
        int dev;
        logic       tx_seen [FRAME];
        logic [8:0] got9;
        logic [8:0] exp9;
        logic [6:0] cw;

        bus.data_in = '0;
        bus.data_valid = 1'b0;

        // Reset and quiet idle
        tick(); tick();
        chk("rst_ready_low", bus.data_ready, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_ready", bus.data_ready, 1'b1);

        // Single frame of 4'b1011: codeword 7'b1010101
        send(4'b1011);
        bus.data_valid = 1'b0;
        t0 = cyc;
        tx_seen[0] = bus.tx;
        for (int i = 1; i < FRAME; i++) begin
            tick();
            tx_seen[i] = bus.tx;
        end
        tick();
        chk("done_at_72", bus.done_pulse, 1'b1);
        chk("len_1011", cyc - t0, FRAME);
        cw = 7'b1010101;
        exp9 = {1'b1, cw, 1'b0};
        dev = 0;
        for (int k = 0; k < 9; k++) begin
            got9[k] = tx_seen[k*CPB + CPB/2];
            for (int s = 0; s < CPB; s++)
                if (tx_seen[k*CPB + s] !== exp9[k]) dev++;
        end
        chk("frame_1011", got9, exp9);
        chk("bit_hold_1011", dev, 0);
        tick(); tick();

        // 0000 then 1111 held valid
        base = n_done;
        send(4'b0000);
        t0 = cyc;
        send(4'b1111);
        bus.data_valid = 1'b0;
        chk("second_xfer_gap", cyc - t0, HOLD ? 1 : FRAME + 1);
        wait_done(base + 2);
        tick(); tick();

        // ena low 3 cycles inside data bit 2
        base = n_done;
        send(4'b1011);
        bus.data_valid = 1'b0;
        t0 = cyc;
        run_until_pos(3*CPB + 3);
        ena = 1'b0;
        tick(); tick(); tick();
        ena = 1'b1;
        wait_done(base + 1);
        chk("len_ena_stretch", cyc - t0, FRAME + 3);
        tick();

        // Reset inside data bit 4, then a clean frame
        send(4'($urandom_range(0, 15)));
        bus.data_valid = 1'b0;
        run_until_pos(5*CPB + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_abort_tx", bus.tx, 1'b1);
        chk("rst_abort_state", bus.state_out, 2'd0);
        tick();
        base = n_done;
        send(4'($urandom_range(0, 15)));
        bus.data_valid = 1'b0;
        t0 = cyc;
        wait_done(base + 1);
        chk("len_after_rst", cyc - t0, FRAME);
        tick();

        // Three nibbles back-to-back
        base = n_done;
        send(4'($urandom_range(0, 15)));
        t0 = cyc;
        send(4'($urandom_range(0, 15)));
        send(4'($urandom_range(0, 15)));
        bus.data_valid = 1'b0;
        wait_done(base + 3);
        chk("len_three", cyc - t0, HOLD ? 3*FRAME : 3*FRAME + 2);
        tick();

        // Random traffic with occasional reset and enable gaps
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            ena = ($urandom_range(0, 9) != 0);
            bus.data_valid = ($urandom_range(0, 2) == 0);
            bus.data_in = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
